// File: rtl/aes_pkg.sv
// Shared constants, buffer FSM encoding and byte-pack helper for the AES block loader.
package aes_pkg;

    localparam int AES_BLK_BYTES = 16;
    localparam int AES_BLK_W     = 128;
    localparam int AES_IDX_W     = $clog2(AES_BLK_BYTES);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } aes_buf_state_e;

    // Appends one byte at the LSB end, so the first byte of a block ends up in the top byte.
    function automatic logic [AES_BLK_W-1:0] pack_byte(input logic [AES_BLK_W-1:0] acc,
                                                      input logic [7:0]           b);
        return {acc[AES_BLK_W-9:0], b};
    endfunction

endpackage

// File: rtl/aes_byte_packer.sv
// One block buffer: shifts 16 key/state byte pairs MSB-first and checks in_last framing.
// Full from the cycle after the 16th pair until drained; loads are ignored while full.
module aes_byte_packer
    import aes_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [7:0]           key_byte,
    input  logic [7:0]           state_byte,
    input  logic                 last,
    input  logic                 drain,
    output logic                 full,
    output logic                 done,
    output logic                 frame_err,
    output logic [AES_BLK_W-1:0] key,
    output logic [AES_BLK_W-1:0] state
);

    aes_buf_state_e       cur;
    aes_buf_state_e       nxt;
    logic [AES_IDX_W-1:0] idx;
    logic                 at_end;
    logic                 take;

    assign at_end = (idx == AES_IDX_W'(AES_BLK_BYTES - 1));
    assign take   = load && (cur == FILL);
    assign full   = (cur == FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            cur <= FILL;
        end else begin
            cur <= nxt;
        end
    end

    always_comb begin
        nxt       = cur;
        done      = 1'b0;
        frame_err = 1'b0;
        case (cur)
            FILL: begin
                if (take) begin
                    if (at_end) begin
                        // A missing in_last on the 16th pair is flagged but the block still ships.
                        nxt       = FULL;
                        done      = 1'b1;
                        frame_err = ~last;
                    end else if (last) begin
                        frame_err = 1'b1;
                    end
                end
            end
            FULL: begin
                if (drain) begin
                    nxt = FILL;
                end
            end
            default: nxt = FILL;
        endcase
    end

    // A short frame only rewinds the index; the stale bytes are overwritten by the next 16 pairs.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx   <= '0;
            key   <= '0;
            state <= '0;
        end else if (take) begin
            key   <= pack_byte(key, key_byte);
            state <= pack_byte(state, state_byte);
            idx   <= (at_end || last) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/aes_block_loader.sv
// Assembles 16 key/plaintext byte pairs into 128-bit blocks for the cipher core; core_valid one cycle after the 16th pair.
// in_ready drops while no buffer can fill; AES_LOADER_DBUF_EN adds a second (ping-pong) buffer.
module aes_block_loader
    import aes_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           key_byte,
    input  logic [7:0]           state_byte,
    input  logic                 in_last,
    output logic                 core_valid,
    input  logic                 core_ready,
    output logic [AES_BLK_W-1:0] core_key,
    output logic [AES_BLK_W-1:0] core_state,
    output logic                 err,
    output logic [7:0]           blk_cnt
);

`ifdef AES_LOADER_DBUF_EN
    localparam int NBUF = 2;
`else
    localparam int NBUF = 1;
`endif

    logic                 wr_sel;
    logic                 rd_sel;
    logic [1:0]           buf_full;
    logic [1:0]           buf_done;
    logic [1:0]           buf_ferr;
    logic [AES_BLK_W-1:0] buf_key   [2];
    logic [AES_BLK_W-1:0] buf_state [2];
    logic                 core_fire;

    // Blocks complete and drain in the same order, so two toggling pointers suffice.
    assign in_ready   = ~rst & ~buf_full[wr_sel];
    assign core_valid = buf_full[rd_sel];
    assign core_key   = buf_key[rd_sel];
    assign core_state = buf_state[rd_sel];
    assign core_fire  = core_valid & core_ready;

    for (genvar g = 0; g < 2; g++) begin : g_buf
        if (g < NBUF) begin : g_inst
            aes_byte_packer u_packer (
                .clk        (clk),
                .rst        (rst),
                .load       (in_valid & in_ready & (wr_sel == 1'(g))),
                .key_byte   (key_byte),
                .state_byte (state_byte),
                .last       (in_last),
                .drain      (core_fire & (rd_sel == 1'(g))),
                .full       (buf_full[g]),
                .done       (buf_done[g]),
                .frame_err  (buf_ferr[g]),
                .key        (buf_key[g]),
                .state      (buf_state[g])
            );
        end else begin : g_tie
            assign buf_full[g]  = 1'b0;
            assign buf_done[g]  = 1'b0;
            assign buf_ferr[g]  = 1'b0;
            assign buf_key[g]   = '0;
            assign buf_state[g] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_sel  <= 1'b0;
            rd_sel  <= 1'b0;
            err     <= 1'b0;
            blk_cnt <= 8'd0;
        end else begin
            if (NBUF > 1 && buf_done[wr_sel]) begin
                wr_sel <= ~wr_sel;
            end
            if (NBUF > 1 && core_fire) begin
                rd_sel <= ~rd_sel;
            end
            if (|buf_ferr) begin
                err <= 1'b1;
            end
            if (core_fire) begin
                blk_cnt <= blk_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_aes_block_loader.sv
// Randomized scoreboard bench for aes_block_loader; honours AES_LOADER_DBUF_EN.
module tb_aes_block_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   key_byte;
    logic [7:0]   state_byte;
    logic         in_last;
    logic         core_valid;
    logic         core_ready;
    logic [127:0] core_key;
    logic [127:0] core_state;
    logic         err;
    logic [7:0]   blk_cnt;

    always #5 clk = ~clk;

    aes_block_loader dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .key_byte   (key_byte),
        .state_byte (state_byte),
        .in_last    (in_last),
        .core_valid (core_valid),
        .core_ready (core_ready),
        .core_key   (core_key),
        .core_state (core_state),
        .err        (err),
        .blk_cnt    (blk_cnt)
    );

    int n_chk  = 0;
    int n_pass = 0;

    function automatic void chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endfunction

    function automatic void note_fail(input string nm);
        n_chk++;
        $display("FAIL %s: bound expired", nm);
    endfunction

    // Reference model: byte queues per frame, expected block queue, sticky error, delivery count.
    logic [7:0]   pk[$];
    logic [7:0]   ps[$];
    logic [255:0] exp_q[$];
    bit           exp_err;
    int           exp_blks;
    bit           rand_rdy = 1'b0;

    function automatic void model_accept(input logic [7:0] k, input logic [7:0] s, input bit l);
        logic [127:0] kk;
        logic [127:0] ss;
        pk.push_back(k);
        ps.push_back(s);
        if (pk.size() == 16) begin
            kk = '0;
            ss = '0;
            for (int i = 0; i < 16; i++) begin
                kk[127-8*i -: 8] = pk[i];
                ss[127-8*i -: 8] = ps[i];
            end
            exp_q.push_back({kk, ss});
            exp_blks++;
            if (!l) exp_err = 1'b1;
            pk.delete();
            ps.delete();
        end else if (l) begin
            exp_err = 1'b1;
            pk.delete();
            ps.delete();
        end
    endfunction

    function automatic void model_reset();
        pk.delete();
        ps.delete();
        exp_q.delete();
        exp_err  = 1'b0;
        exp_blks = 0;
    endfunction

    // Monitor: pops an expected block on every core transfer and checks stability during stalls.
    logic [255:0] held;
    bit           was_hold = 1'b0;
    always @(negedge clk) begin
        logic [255:0] e;
        if (rst) begin
            was_hold = 1'b0;
        end else begin
            if (was_hold) begin
                chk("hold_valid", 256'(core_valid), 256'(1));
                chk("hold_data", {core_key, core_state}, held);
            end
            if (core_valid && core_ready) begin
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_block: got %0h expected no block", core_key);
                    n_chk++;
                end else begin
                    e = exp_q.pop_front();
                    chk("core_key", 256'(core_key), 256'(e[255:128]));
                    chk("core_state", 256'(core_state), 256'(e[127:0]));
                end
            end
            was_hold = core_valid && !core_ready;
            held     = {core_key, core_state};
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_rdy) core_ready = ($urandom_range(0, 2) != 0);
        end
    end

    task automatic send_pair(input logic [7:0] k, input logic [7:0] s, input bit l);
        int t = 0;
        in_valid   = 1'b1;
        key_byte   = k;
        state_byte = s;
        in_last    = l;
        while (!in_ready && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!in_ready) note_fail("in_ready_timeout");
        else model_accept(k, s, l);
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        key_byte   = 8'($urandom);
        state_byte = 8'($urandom);
        in_last    = 1'($urandom);
    endtask

    task automatic send_block(input logic [127:0] k, input logic [127:0] s,
                              input bit drop_last, input bit gaps);
        for (int i = 0; i < 16; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send_pair(k[127-8*i -: 8], s[127-8*i -: 8], (i == 15) && !drop_last);
        end
    endtask

    task automatic drain();
        int t = 0;
        rand_rdy   = 1'b0;
        core_ready = 1'b1;
        while ((exp_q.size() != 0 || core_valid) && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 200) note_fail("drain_timeout");
    endtask

    task automatic do_reset(input bit check);
        rst        = 1'b1;
        in_valid   = 1'b0;
        rand_rdy   = 1'b0;
        core_ready = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        if (check) begin
            chk("rst_core_valid", 256'(core_valid), 256'(0));
            chk("rst_in_ready", 256'(in_ready), 256'(0));
            chk("rst_err", 256'(err), 256'(0));
            chk("rst_blk_cnt", 256'(blk_cnt), 256'(0));
            chk("rst_core_key", 256'(core_key), 256'(0));
            chk("rst_core_state", 256'(core_state), 256'(0));
        end
        rst = 1'b0;
        #1;
        if (check) chk("in_ready_after_rst", 256'(in_ready), 256'(1));
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] k;
        logic [127:0] s;
        rst        = 1'b1;
        in_valid   = 1'b0;
        key_byte   = 8'h00;
        state_byte = 8'h00;
        in_last    = 1'b0;
        core_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset(1'b1);

        // Known-answer block, back-to-back pairs, core always ready.
        core_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send_pair(8'(i), 8'(i * 17), i == 15);
            if (i == 14) chk("valid_before_16th", 256'(core_valid), 256'(0));
        end
        chk("valid_after_16th", 256'(core_valid), 256'(1));
        chk("kat_key", 256'(core_key), 256'(128'h000102030405060708090a0b0c0d0e0f));
        chk("kat_state", 256'(core_state), 256'(128'h00112233445566778899aabbccddeeff));
        drain();
        chk("kat_blk_cnt", 256'(blk_cnt), 256'(1));
        chk("kat_err", 256'(err), 256'(0));

        // Core stalls 20 cycles; block must stay put and go on the first ready cycle.
        core_ready = 1'b0;
        send_block(rnd128(), rnd128(), 1'b0, 1'b0);
        chk("stall_valid", 256'(core_valid), 256'(1));
        repeat (20) @(posedge clk);
        #1;
        chk("stall_valid_20", 256'(core_valid), 256'(1));
        core_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_released", 256'(core_valid), 256'(0));
        chk("stall_blk_cnt", 256'(blk_cnt), 256'(2));

        // Early in_last on the 5th pair: error, nothing delivered, next block clean.
        for (int i = 0; i < 5; i++) send_pair(8'($urandom), 8'($urandom), i == 4);
        chk("short_err", 256'(err), 256'(1));
        repeat (3) @(posedge clk);
        #1;
        chk("short_no_valid", 256'(core_valid), 256'(0));
        send_block(rnd128(), rnd128(), 1'b0, 1'b1);
        drain();
        chk("short_blk_cnt", 256'(blk_cnt), 256'(3));
        chk("short_err_sticky", 256'(err), 256'(exp_err));

        // Fill with the core stalled: buffer occupancy controls in_ready.
        core_ready = 1'b0;
        send_block(rnd128(), rnd128(), 1'b0, 1'b0);
`ifdef AES_LOADER_DBUF_EN
        chk("dbuf_ready_after_16", 256'(in_ready), 256'(1));
        send_block(rnd128(), rnd128(), 1'b0, 1'b0);
        chk("dbuf_ready_after_32", 256'(in_ready), 256'(0));
`else
        chk("sbuf_ready_after_16", 256'(in_ready), 256'(0));
`endif
        drain();
        chk("fill_blk_cnt", 256'(blk_cnt), 256'(8'(3 + exp_blks - 3)));

        // Reset in the middle of a block discards it; the next block is clean.
        for (int i = 0; i < 9; i++) send_pair(8'($urandom), 8'($urandom), 1'b0);
        do_reset(1'b1);
        k = rnd128();
        s = rnd128();
        core_ready = 1'b1;
        send_block(k, s, 1'b0, 1'b0);
        drain();
        chk("post_rst_blk_cnt", 256'(blk_cnt), 256'(1));
        chk("post_rst_err", 256'(err), 256'(0));

        // 257 random deliveries with gaps, random core_ready and occasional framing faults.
        do_reset(1'b0);
        rand_rdy = 1'b1;
        for (int b = 0; b < 257; b++) begin
            if ($urandom_range(0, 9) == 0) begin
                int n = $urandom_range(1, 15);
                for (int i = 0; i < n; i++) send_pair(8'($urandom), 8'($urandom), i == n - 1);
            end
            send_block(rnd128(), rnd128(), $urandom_range(0, 7) == 0, 1'b1);
        end
        drain();
        chk("wrap_exp_blks", 256'(exp_blks), 256'(257));
        chk("wrap_blk_cnt", 256'(blk_cnt), 256'(1));
        chk("wrap_err", 256'(err), 256'(exp_err));
        chk("wrap_idle_ready", 256'(in_ready), 256'(1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
